// File: rtl/ngv_halfbridge_drv.sv
// Half-bridge gate driver: non-overlapping high/low gate enables with dead time, min-on time,
// and a latched fault. Optional 16-bit gate-entry counter is enabled by NGV_DRV_EDGE_CNT_EN.
module ngv_halfbridge_drv #(
    parameter int unsigned DEAD_CYC   = 16,
    parameter int unsigned MIN_ON_CYC = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        phase_in,
    input  logic        fault,
    input  logic        fault_clr,
    output logic        hs_out,
    output logic        ls_out,
    output logic        fault_latched,
    output logic        busy
`ifdef NGV_DRV_EDGE_CNT_EN
    ,
    output logic [15:0] edge_cnt
`endif
);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_DEAD  = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LD  = CNT_W'(MIN_ON_CYC - 1);

    if ((DEAD_CYC == 0) || (64'(DEAD_CYC) >= (64'd1 << CNT_W))) begin : gen_bad_dead
        $error("DEAD_CYC must be in 1..2^CNT_W-1");
    end
    if ((MIN_ON_CYC == 0) || (64'(MIN_ON_CYC) >= (64'd1 << CNT_W))) begin : gen_bad_min_on
        $error("MIN_ON_CYC must be in 1..2^CNT_W-1");
    end

    logic             ph_meta;
    logic             ph_s;
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_meta <= 1'b0;
            ph_s    <= 1'b0;
        end else begin
            ph_meta <= phase_in;
            ph_s    <= ph_meta;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fault) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
        end else if (state_q == ST_FAULT) begin
            if (fault_clr) begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        end else if (!en) begin
            // Turning off needs no dead time: both gates simply drop.
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_DEAD;
                    cnt_d   = DEAD_LD;
                end
                ST_DEAD: begin
                    if (cnt_q == '0) begin
                        state_d = ph_s ? ST_HIGH : ST_LOW;
                        cnt_d   = MIN_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!ph_s) begin
                        state_d = ST_DEAD;
                        cnt_d   = DEAD_LD;
                    end
                end
                ST_LOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (ph_s) begin
                        state_d = ST_DEAD;
                        cnt_d   = DEAD_LD;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they equal a decode of state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_OFF;
            cnt_q         <= '0;
            hs_out        <= 1'b0;
            ls_out        <= 1'b0;
            busy          <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hs_out        <= (state_d == ST_HIGH);
            ls_out        <= (state_d == ST_LOW);
            busy          <= (state_d == ST_DEAD);
            fault_latched <= (state_d == ST_FAULT);
        end
    end

`ifdef NGV_DRV_EDGE_CNT_EN
    logic gate_entry;
    logic fault_entry;

    assign gate_entry  = (state_q == ST_DEAD) && ((state_d == ST_HIGH) || (state_d == ST_LOW));
    assign fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);

    always_ff @(posedge clk) begin
        if (rst || fault_entry) begin
            edge_cnt <= 16'h0000;
        end else if (gate_entry) begin
            edge_cnt <= edge_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_ngv_halfbridge_drv.sv
// Scoreboard bench for ngv_halfbridge_drv (DEAD_CYC=4, MIN_ON_CYC=3): directed vectors push
// expected {hs,ls,busy,fault_latched} per cycle; a negedge monitor pops and compares.
module tb_ngv_halfbridge_drv;

    localparam int unsigned DEAD  = 4;
    localparam int unsigned MINON = 3;

    localparam logic [3:0] V_OFF = 4'b0000;
    localparam logic [3:0] V_HS  = 4'b1000;
    localparam logic [3:0] V_LS  = 4'b0100;
    localparam logic [3:0] V_BSY = 4'b0010;
    localparam logic [3:0] V_FLT = 4'b0001;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic en        = 1'b1;
    logic phase_in  = 1'b1;
    logic fault     = 1'b0;
    logic fault_clr = 1'b0;
    logic hs_out;
    logic ls_out;
    logic fault_latched;
    logic busy;
`ifdef NGV_DRV_EDGE_CNT_EN
    logic [15:0] edge_cnt;
`endif

    ngv_halfbridge_drv #(
        .DEAD_CYC  (DEAD),
        .MIN_ON_CYC(MINON),
        .CNT_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .phase_in     (phase_in),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .hs_out       (hs_out),
        .ls_out       (ls_out),
        .fault_latched(fault_latched),
        .busy         (busy)
`ifdef NGV_DRV_EDGE_CNT_EN
        ,
        .edge_cnt     (edge_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic chk_inv     = 1'b0;
    logic prev_on     = 1'b0;
    logic prev_hs     = 1'b0;
    logic prev_ls     = 1'b0;
    int   run_len     = 0;
    int   gap_len     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_rng(input int lo, input int hi, input logic [3:0] val,
                              input string name);
        exp_t e;
        for (int c = lo; c <= hi; c++) begin
            e.cyc  = cyc + c;
            e.val  = val;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    // Monitor: scoreboard pops plus cycle-level gate invariants.
    always @(negedge clk) begin
        logic [3:0] obs;
        logic       on;
        exp_t       e;
        obs = {hs_out, ls_out, busy, fault_latched};
        on  = hs_out | ls_out;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if (e.cyc < cyc) begin
                miscompares++;
                $display("FAIL %s: expectation for cyc %0d missed (now cyc %0d)", e.name, e.cyc,
                         cyc);
            end else if (obs !== e.val) begin
                miscompares++;
                $display("FAIL %s @cyc %0d: got hs/ls/busy/flt=%b, want %b", e.name, cyc, obs,
                         e.val);
            end
        end
        if (!rst) begin
            vectors++;
            if ((hs_out === 1'b1 && ls_out === 1'b1) || (prev_hs && ls_out === 1'b1) ||
                (prev_ls && hs_out === 1'b1)) begin
                miscompares++;
                $display("FAIL overlap @cyc %0d: hs=%b ls=%b prev hs=%b ls=%b", cyc, hs_out,
                         ls_out, prev_hs, prev_ls);
            end
        end
        if (chk_inv) begin
            if (on && !prev_on) begin
                vectors++;
                if (gap_len != DEAD) begin
                    miscompares++;
                    $display("FAIL dead_gap @cyc %0d: got %0d both-low clocks, want %0d", cyc,
                             gap_len, DEAD);
                end
            end
            if (!on && prev_on) begin
                vectors++;
                if (run_len < MINON) begin
                    miscompares++;
                    $display("FAIL min_on @cyc %0d: got %0d on clocks, want >= %0d", cyc,
                             run_len, MINON);
                end
            end
        end
        if (on === 1'b1) begin
            run_len = prev_on ? run_len + 1 : 1;
            gap_len = 0;
        end else begin
            run_len = 0;
            gap_len = gap_len + 1;
        end
        prev_on = (on === 1'b1);
        prev_hs = (hs_out === 1'b1);
        prev_ls = (ls_out === 1'b1);
    end

    initial begin
        // Reset exit: gates low in reset, 4 clocks DEAD, then high side.
        step(1);
        repeat (4) begin
            expect_rng(0, 0, V_OFF, "reset_hold");
            step(1);
        end
        rst = 1'b0;
        expect_rng(0, 0, V_OFF, "reset_last");
        expect_rng(1, 4, V_BSY, "reset_dead");
        expect_rng(5, 7, V_HS, "reset_hs");
        step(7);

        // Phase toggle 1->0, then a 1-clock high glitch right as LOW is entered.
        phase_in = 1'b0;
        expect_rng(1, 2, V_HS, "toggle_latency");
        expect_rng(3, 6, V_BSY, "toggle_dead");
        expect_rng(7, 14, V_LS, "toggle_ls_glitch");
        step(6);
        phase_in = 1'b1;
        step(1);
        phase_in = 1'b0;
        step(7);

        // Back to HIGH, then fault handling.
        phase_in = 1'b1;
        expect_rng(1, 2, V_LS, "to_hs_latency");
        expect_rng(3, 6, V_BSY, "to_hs_dead");
        expect_rng(7, 8, V_HS, "to_hs_on");
        step(8);
        fault = 1'b1;
        expect_rng(1, 1, V_FLT, "fault_entry");
        step(1);
        fault     = 1'b1;
        fault_clr = 1'b1;
        expect_rng(1, 1, V_FLT, "fault_beats_clr");
        step(1);
        fault     = 1'b0;
        fault_clr = 1'b0;
        en        = 1'b0;
        expect_rng(1, 1, V_FLT, "fault_ignores_en");
        step(1);
        en = 1'b1;
        expect_rng(1, 1, V_FLT, "fault_held");
        step(1);
        fault_clr = 1'b1;
        expect_rng(1, 1, V_OFF, "fault_clr_off");
        expect_rng(2, 5, V_BSY, "fault_clr_dead");
        expect_rng(6, 6, V_HS, "fault_clr_hs");
        step(1);
        fault_clr = 1'b0;
        step(6);

        // Enable drop mid-DEAD and mid-HIGH.
        phase_in = 1'b0;
        expect_rng(0, 2, V_HS, "pre_drop_hs");
        expect_rng(3, 4, V_BSY, "pre_drop_dead");
        step(4);
        en = 1'b0;
        expect_rng(1, 2, V_OFF, "drop_mid_dead");
        step(2);
        en       = 1'b1;
        phase_in = 1'b1;
        expect_rng(1, 4, V_BSY, "reen_dead");
        expect_rng(5, 6, V_HS, "reen_hs");
        step(6);
        en = 1'b0;
        expect_rng(1, 2, V_OFF, "drop_mid_high");
        step(2);
        en = 1'b1;
        expect_rng(1, 4, V_BSY, "reen2_dead");
        expect_rng(5, 5, V_HS, "reen2_hs");
        step(6);

        // Random toggles under continuous invariant checking.
        chk_inv = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            phase_in = ~phase_in;
            step(int'($urandom_range(1, 10)));
        end
        chk_inv = 1'b0;

`ifdef NGV_DRV_EDGE_CNT_EN
        phase_in = 1'b1;
        step(20);
        fault = 1'b1;
        step(1);
        fault = 1'b0;
        vectors++;
        if (edge_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL edge_cnt_fault_clear: got %0d, want 0", edge_cnt);
        end
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        step(10);
        for (int i = 0; i < 10; i++) begin
            phase_in = ~phase_in;
            step(12);
        end
        vectors++;
        if (edge_cnt !== 16'd11) begin
            miscompares++;
            $display("FAIL edge_cnt_toggles: got %0d, want 11", edge_cnt);
        end
`endif

        step(3);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
